// File: rtl/mem_responder.sv
// Word-organised single-port RAM acting as the responder end of the req/gnt/rvalid
// data interface, with programmable wait states. Optional stall input: MEM_RESPONDER_STALL_EN.
module mem_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef MEM_RESPONDER_STALL_EN
  input  logic                    stall_i,
`endif
  input  logic                    data_req_i,
  input  logic                    data_we_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o
);

  localparam int unsigned NB     = DATA_WIDTH / 8;
  localparam int unsigned OFF    = $clog2(NB);
  localparam int unsigned IDX_W  = ADDR_WIDTH - OFF;
  localparam int unsigned DEPTH  = 2 ** IDX_W;
  localparam int unsigned WCNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(WAIT_STATES);

  logic              stall;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef MEM_RESPONDER_STALL_EN
  assign stall = stall_i;
`else
  assign stall = 1'b0;
`endif

  assign idx        = data_addr_i[ADDR_WIDTH-1:OFF];
  assign data_gnt_o = data_req_i && (wcnt == WCNT_MAX) && !stall;

  // Sub-word address bits carry no meaning for a word-organised array.
  if (OFF > 0) begin : g_lo
    logic unused_addr_lo;
    assign unused_addr_lo = ^data_addr_i[OFF-1:0];
  end

  // A dropped request always clears; a stall freezes the count otherwise.
  always_comb begin
    wcnt_nxt = wcnt;
    if (!data_req_i) begin
      wcnt_nxt = '0;
    end else if (stall) begin
      wcnt_nxt = wcnt;
    end else if (data_gnt_o) begin
      wcnt_nxt = '0;
    end else if (wcnt != WCNT_MAX) begin
      wcnt_nxt = wcnt + WCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt          <= '0;
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
    end else begin
      wcnt          <= wcnt_nxt;
      data_rvalid_o <= data_gnt_o;
      if (data_gnt_o) begin
        data_rdata_o <= data_we_i ? '0 : mem[idx];
      end
    end
  end

  // Storage has no reset; the read above sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (data_gnt_o && data_we_i) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (data_be_i[k]) begin
          mem[idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: four instances with WAIT_STATES 0..3, directed
// vectors and sequences plus randomized traffic checked by a transaction-level model.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [3:0]       req, we, stall, gnt, rvalid;
  logic [3:0][9:0]  addr;
  logic [3:0][3:0]  be;
  logic [3:0][31:0] wdata, rdata;

`ifdef MEM_RESPONDER_STALL_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_responder #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (10),
      .WAIT_STATES(g)
    ) dut (
      .clk          (clk),
      .rst          (rst),
`ifdef MEM_RESPONDER_STALL_EN
      .stall_i      (stall[g]),
`endif
      .data_req_i   (req[g]),
      .data_we_i    (we[g]),
      .data_addr_i  (addr[g]),
      .data_be_i    (be[g]),
      .data_wdata_i (wdata[g]),
      .data_gnt_o   (gnt[g]),
      .data_rvalid_o(rvalid[g]),
      .data_rdata_o (rdata[g])
    );
  end

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Transaction-level model: each instance d needs d uninterrupted, unstalled
  // request cycles before granting; each grant yields one response next cycle.
  int          pend   [4];
  bit          exp_rv [4];
  logic [31:0] exp_rd [4];
  logic [31:0] exp_m  [4];
  logic [31:0] mm     [4][256];
  bit   [3:0]  mk     [4][256];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 4; d++) begin
        bit eg;
        bit st;
        int ix;
        st = STALL_ON && stall[d];
        eg = req[d] && (pend[d] >= d) && !st;
        check($sformatf("gnt[%0d]", d), {31'b0, gnt[d]}, {31'b0, eg});
        check($sformatf("rvalid[%0d]", d), {31'b0, rvalid[d]}, {31'b0, exp_rv[d]});
        if (exp_rv[d] && exp_m[d] != 0)
          check($sformatf("rdata[%0d]", d), rdata[d] & exp_m[d], exp_rd[d] & exp_m[d]);
        ix = int'(addr[d][9:2]);
        exp_rv[d] = eg;
        if (eg) begin
          pend[d] = 0;
          if (we[d]) begin
            exp_rd[d] = '0;
            exp_m[d]  = '1;
            for (int k = 0; k < 4; k++) begin
              if (be[d][k]) begin
                mm[d][ix][8*k +: 8] = wdata[d][8*k +: 8];
                mk[d][ix][k] = 1'b1;
              end
            end
          end else begin
            exp_rd[d] = mm[d][ix];
            for (int k = 0; k < 4; k++) exp_m[d][8*k +: 8] = {8{mk[d][ix][k]}};
          end
        end else if (!req[d]) begin
          pend[d] = 0;
        end else if (!st && pend[d] < d) begin
          pend[d] = pend[d] + 1;
        end
      end
    end
  end

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[25];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input int d, input logic w, input logic [9:0] a,
                           input logic [3:0] b, input logic [31:0] wd);
    int n;
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    n = 0;
    forever begin
      @(negedge clk);
      if (gnt[d]) break;
      n++;
      if (n > 64) begin
        check($sformatf("grant timeout[%0d]", d), {31'b0, gnt[d]}, 32'd1);
        break;
      end
    end
    tick();
    req[d] = 1'b0;
  endtask

  task automatic rand_driver(input int d, input int n_ops);
    int w;
    logic [7:0] ix;
    for (int i = 0; i < 17; i++) begin
      ix = (i == 16) ? 8'hFF : 8'(i);
      do_access(d, 1'b1, {ix, 2'b00}, 4'hF, $urandom);
    end
    for (int i = 0; i < n_ops; i++) begin
      repeat ($urandom % 3) begin
        we[d] = 1'($urandom); addr[d] = 10'($urandom); be[d] = 4'($urandom);
        tick();
      end
      if (d > 0 && ($urandom % 6) == 0) begin
        req[d] = 1'b1;
        repeat (1 + ($urandom % d)) tick();
        req[d] = 1'b0;
        tick();
      end else begin
        w  = $urandom % 17;
        ix = (w == 16) ? 8'hFF : 8'(w);
        do_access(d, 1'($urandom), {ix, 2'($urandom)}, 4'($urandom), $urandom);
      end
    end
  endtask

  bit rand_phase = 1'b0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 10'h010, 4'hF, 32'hDEADBEEF, 32'h0};
    vt[1] = '{1'b0, 10'h010, 4'h0, 32'h0,        32'hDEADBEEF};
    vt[2] = '{1'b1, 10'h010, 4'h5, 32'h11223344, 32'h0};
    vt[3] = '{1'b0, 10'h010, 4'h0, 32'h0,        32'hDE22BE44};
    vt[4] = '{1'b1, 10'h3FC, 4'hF, 32'hA5A5A5A5, 32'h0};
    vt[5] = '{1'b1, 10'h3FC, 4'h0, 32'hFFFFFFFF, 32'h0};
    vt[6] = '{1'b0, 10'h3FF, 4'h0, 32'h0,        32'hA5A5A5A5};
    vt[7] = '{1'b1, 10'h3FD, 4'hA, 32'h5A00C300, 32'h0};
    vt[8] = '{1'b0, 10'h3FC, 4'h0, 32'h0,        32'h5AA5C3A5};
    for (int w = 0; w < 8; w++) begin
      vt[9 + w]  = '{1'b1, 10'(4 * w), 4'hF, 32'hC0DE0000 | 32'(w * 32'h1111), 32'h0};
      vt[17 + w] = '{1'b0, 10'(4 * w), 4'h0, 32'h0, 32'hC0DE0000 | 32'(w * 32'h1111)};
    end

    rst = 1'b1; req = '0; we = '0; stall = '0; addr = '0; be = '0; wdata = '0;
    for (int d = 0; d < 4; d++) begin
      pend[d] = 0; exp_rv[d] = 1'b0; exp_rd[d] = '0; exp_m[d] = '0;
      for (int i = 0; i < 256; i++) begin mm[d][i] = '0; mk[d][i] = '0; end
    end
    repeat (3) tick();
    req = 4'b1110;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("reset rvalid[%0d]", d), {31'b0, rvalid[d]}, 32'd0);
      check($sformatf("reset rdata[%0d]", d), rdata[d], 32'd0);
      if (d > 0) check($sformatf("reset gnt[%0d]", d), {31'b0, gnt[d]}, 32'd0);
    end
    tick();
    rst = 1'b0; req = 4'b0010; chk_en = 1'b1;

    // One wait state: grant in the 2nd request cycle, response in the 3rd.
    @(negedge clk); check("ws1 gnt c1", {31'b0, gnt[1]}, 32'd0);
    tick();
    @(negedge clk); check("ws1 gnt c2", {31'b0, gnt[1]}, 32'd1);
    check("ws1 rvalid c2", {31'b0, rvalid[1]}, 32'd0);
    tick(); req[1] = 1'b0;
    @(negedge clk); check("ws1 rvalid c3", {31'b0, rvalid[1]}, 32'd1);
    tick();

    // Zero wait states, back-to-back vectors with held request.
    for (int i = 0; i < 25; i++) begin
      req[0] = 1'b1; we[0] = vt[i].we; addr[0] = vt[i].addr;
      be[0] = vt[i].be; wdata[0] = vt[i].wdata;
      @(negedge clk);
      check($sformatf("vec%0d gnt", i), {31'b0, gnt[0]}, 32'd1);
      if (i > 0) begin
        check($sformatf("vec%0d rvalid", i - 1), {31'b0, rvalid[0]}, 32'd1);
        check($sformatf("vec%0d rdata", i - 1), rdata[0], vt[i - 1].exp_rdata);
      end
      tick();
    end
    req[0] = 1'b0;
    @(negedge clk);
    check("vec24 rvalid", {31'b0, rvalid[0]}, 32'd1);
    check("vec24 rdata", rdata[0], vt[24].exp_rdata);
    tick();
    @(negedge clk); check("stream end rvalid", {31'b0, rvalid[0]}, 32'd0);
    tick();

    // Three wait states: abandoned request, then a full one.
    req[3] = 1'b1; we[3] = 1'b0; addr[3] = 10'h3FC;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      check($sformatf("abandon gnt c%0d", c), {31'b0, gnt[3]}, 32'd0);
      tick();
    end
    req[3] = 1'b0;
    @(negedge clk); check("abandon gap gnt", {31'b0, gnt[3]}, 32'd0);
    tick();
    req[3] = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("retry gnt c%0d", c), {31'b0, gnt[3]}, {31'b0, c == 4});
      check($sformatf("retry rvalid c%0d", c), {31'b0, rvalid[3]}, 32'd0);
      tick();
    end
    req[3] = 1'b0;
    @(negedge clk); check("retry rvalid", {31'b0, rvalid[3]}, 32'd1);
    tick();

`ifdef MEM_RESPONDER_STALL_EN
    // Two wait states with a 3-cycle stall starting at request cycle 2.
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 10'h000;
    for (int c = 1; c <= 6; c++) begin
      stall[2] = (c >= 2 && c <= 4);
      @(negedge clk);
      check($sformatf("stall gnt c%0d", c), {31'b0, gnt[2]}, {31'b0, c == 6});
      tick();
    end
    stall[2] = 1'b0; req[2] = 1'b0;
    @(negedge clk); check("stall rvalid", {31'b0, rvalid[2]}, 32'd1);
    tick();
`endif

    rand_phase = 1'b1;
    fork
      rand_driver(0, 150);
      rand_driver(1, 150);
      rand_driver(2, 150);
      rand_driver(3, 150);
    join
    rand_phase = 1'b0;
    req = '0; stall = '0;
    repeat (3) tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    @(posedge rand_phase);
    while (rand_phase) begin
      @(posedge clk);
      #1;
      if (STALL_ON && rand_phase) begin
        for (int d = 0; d < 4; d++) stall[d] = (($urandom % 4) == 0);
      end
    end
    stall = '0;
  end

endmodule
